// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the CPU front end.
//   WORD_W        - datapath / address width
//   PC_STEP       - byte increment between sequential instruction words
//   fetch_entry_t - one fetched instruction together with its PC
package cpu_pkg;

  localparam int unsigned       WORD_W  = 32;
  localparam logic [WORD_W-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: in-order entry storage for the fetch queue.
//   clk, reset (async, active-low)
//   push / push_data - write one entry at the tail
//   pop              - remove the head (ignored when empty)
//   flush            - drop every entry; a pop in the same cycle is simply absorbed
//   head             - head entry, all-zero while empty
//   count            - number of stored entries (0..DEPTH)
module ifq_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t  entries [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && (count != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) entries[wr_ptr] <= push_data;
  end

  assign head = (count != '0) ? entries[rd_ptr] : '0;

endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: fetch stage feeding decode.
// Owns the fetch PC, keeps at most one read outstanding to instruction memory,
// queues returned words with their PCs and hands them out over valid/ready.
// A redirect flushes the queue, drops any still-outstanding response and
// restarts fetch at the target.
//   clk, reset (async, active-low)
//   mem_req/mem_addr          - word read request to instruction memory
//   mem_rdata/mem_rvalid      - one response per accepted request
//   redirect_valid/redirect_pc- taken branch/jump
//   instr_valid/instr/instr_pc/instr_ready - decode handshake
//   align_err                 - sticky misaligned-redirect flag
// Build option IFQ_ALIGN_CHECK_EN: a misaligned redirect sets align_err and
// halts fetch until reset; otherwise the target's low two bits are cleared.
module instr_fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [WORD_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic              align_err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WORD_W-1:0] fpc;
  logic [WORD_W-1:0] req_pc;
  logic              osd;
  logic              drp;
  logic              halted;
  logic              load_pc;
  logic [WORD_W-1:0] target;
  logic [CW-1:0]     count;
  logic [CW:0]       inflight;
  logic              push;
  logic              pop;
  fetch_entry_t      head;

`ifdef IFQ_ALIGN_CHECK_EN
  logic misaligned;
  logic align_q;

  assign misaligned = (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            align_q <= 1'b0;
    else if (redirect_valid && misaligned) align_q <= 1'b1;
  end

  assign halted    = align_q;
  assign align_err = align_q;
  assign load_pc   = !misaligned;
  assign target    = redirect_pc;
`else
  assign halted    = 1'b0;
  assign align_err = 1'b0;
  assign load_pc   = 1'b1;
  assign target    = redirect_pc & ~32'h3;
`endif

  // Every outstanding request already owns a queue slot, so the queue can never overflow.
  assign inflight = {1'b0, count} + {{CW{1'b0}}, osd};
  assign mem_req  = reset && !redirect_valid && !halted && (!osd || mem_rvalid)
                    && (inflight < (CW+1)'(DEPTH));
  assign mem_addr = fpc;

  assign push = mem_rvalid && !drp && !redirect_valid;
  assign pop  = instr_valid && instr_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc    <= RESET_PC;
      req_pc <= '0;
      osd    <= 1'b0;
      drp    <= 1'b0;
    end else begin
      if (redirect_valid) begin
        if (load_pc) fpc <= target;
      end else if (mem_req) begin
        fpc <= fpc + PC_STEP;
      end

      if (mem_req) begin
        osd    <= 1'b1;
        req_pc <= fpc;
      end else if (mem_rvalid) begin
        osd    <= 1'b0;
      end

      // A request still in flight at redirect time belongs to the old path.
      if (redirect_valid)  drp <= osd && !mem_rvalid;
      else if (mem_rvalid) drp <= 1'b0;
    end
  end

  ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ('{pc: req_pc, instr: mem_rdata}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (count)
  );

  assign instr_valid = (count != '0);
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed bench for instr_fetch_queue with a one-deep
// instruction memory model returning addr + 0x1000; the response can be held
// back with mem_stall. Expectations follow IFQ_ALIGN_CHECK_EN when defined.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        align_err;

  int          checks = 0;
  int          failures = 0;

  logic        pend = 1'b0;
  logic [31:0] paddr = '0;
  logic        mem_stall = 1'b0;

  always #5 clk = ~clk;

  instr_fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .mem_rvalid     (mem_rvalid),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .align_err      (align_err)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: memory samples the request at negedge, answers after the posedge.
  task automatic tick();
    logic        took;
    logic        req;
    logic [31:0] a;
    @(negedge clk);
    took = mem_rvalid;
    req  = mem_req;
    a    = mem_addr;
    @(posedge clk);
    #1;
    if (took) pend = 1'b0;
    if (req) begin
      pend  = 1'b1;
      paddr = a;
    end
    mem_rvalid = pend && !mem_stall;
    mem_rdata  = mem_rvalid ? paddr + 32'h1000 : '0;
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    pend           = 1'b0;
    mem_rvalid     = 1'b0;
    mem_rdata      = '0;
    mem_stall      = 1'b0;
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    #1;
    chk1 ("rst_req",   mem_req,     1'b0);
    chk32("rst_addr",  mem_addr,    32'h0);
    chk1 ("rst_valid", instr_valid, 1'b0);
    chk32("rst_instr", instr,       32'h0);
    chk32("rst_pc",    instr_pc,    32'h0);
    chk1 ("rst_align", align_err,   1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  logic [31:0] wrap_pc [3];

  initial begin
    wrap_pc[0] = 32'hFFFF_FFF8;
    wrap_pc[1] = 32'hFFFF_FFFC;
    wrap_pc[2] = 32'h0000_0000;

    #2;
    do_reset();

    // Streaming from reset
    instr_ready = 1'b1;
    #2;
    chk1 ("c0_req",   mem_req,     1'b1);
    chk32("c0_addr",  mem_addr,    32'h0);
    chk1 ("c0_valid", instr_valid, 1'b0);
    tick();
    #2;
    chk32("c1_addr",  mem_addr,    32'h4);
    chk1 ("c1_valid", instr_valid, 1'b0);
    tick();
    for (int c = 2; c < 8; c++) begin
      #2;
      chk1 ("stream_valid", instr_valid, 1'b1);
      chk32("stream_pc",    instr_pc,    32'(4 * (c - 2)));
      chk32("stream_instr", instr,       32'h1000 + 32'(4 * (c - 2)));
      chk32("stream_addr",  mem_addr,    32'(4 * c));
      tick();
    end

    // Back-pressure: queue fills to DEPTH, then fetch stops
    instr_ready = 1'b0;
    for (int c = 8; c < 18; c++) begin
      #2;
      chk1 ("stall_valid", instr_valid, 1'b1);
      chk32("stall_pc",    instr_pc,    32'h18);
      if (c >= 10) chk1("stall_req_off", mem_req, 1'b0);
      else         chk1("stall_req_on",  mem_req, 1'b1);
      tick();
    end
    instr_ready = 1'b1;
    for (int c = 18; c < 25; c++) begin
      #2;
      chk1 ("drain_valid", instr_valid, 1'b1);
      chk32("drain_pc",    instr_pc,    32'h18 + 32'(4 * (c - 18)));
      chk32("drain_instr", instr,       32'h1018 + 32'(4 * (c - 18)));
      tick();
    end

    // Reset mid-operation, then redirect with 3 queued + 1 outstanding
    do_reset();
    for (int c = 0; c < 4; c++) begin
      if (c == 3) mem_stall = 1'b1;
      #2;
      chk32("fill_addr", mem_addr, 32'(4 * c));
      tick();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    mem_stall      = 1'b0;
    #2;
    chk1 ("rd1_req",   mem_req,     1'b0);
    chk1 ("rd1_valid", instr_valid, 1'b1);
    chk32("rd1_pc",    instr_pc,    32'h0);
    tick();
    redirect_valid = 1'b0;
    #2;
    chk1 ("rd1_flushed", instr_valid, 1'b0);
    chk1 ("rd1_new_req", mem_req,     1'b1);
    chk32("rd1_new_addr", mem_addr,   32'h40);
    tick();
    #2;
    chk1 ("rd1_stale_dropped", instr_valid, 1'b0);
    tick();
    instr_ready = 1'b1;
    #2;
    chk1 ("rd1_tgt_valid", instr_valid, 1'b1);
    chk32("rd1_tgt_pc",    instr_pc,    32'h40);
    chk32("rd1_tgt_instr", instr,       32'h1040);
    tick();

    // Redirect coinciding with a response and a pop, to a wrapping target
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    #2;
    chk1 ("rd2_rvalid", mem_rvalid,  1'b1);
    chk1 ("rd2_valid",  instr_valid, 1'b1);
    chk32("rd2_pc",     instr_pc,    32'h44);
    chk1 ("rd2_req",    mem_req,     1'b0);
    tick();
    redirect_valid = 1'b0;
    #2;
    chk1 ("rd2_flushed", instr_valid, 1'b0);
    chk32("rd2_addr",    mem_addr,    32'hFFFF_FFF8);
    tick();
    #2;
    chk1 ("rd2_resp_dropped", instr_valid, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
      end
      #2;
      chk1 ("wrap_valid", instr_valid, 1'b1);
      chk32("wrap_pc",    instr_pc,    wrap_pc[k]);
      chk32("wrap_instr", instr,       wrap_pc[k] + 32'h1000);
      tick();
    end
    redirect_valid = 1'b0;

    // Misaligned redirect to 0x42
`ifdef IFQ_ALIGN_CHECK_EN
    #2;
    chk1("mis_align_err", align_err,   1'b1);
    chk1("mis_req",       mem_req,     1'b0);
    chk1("mis_valid",     instr_valid, 1'b0);
    tick();
    #2;
    chk1("mis_req_held",  mem_req,     1'b0);
    chk1("mis_err_held",  align_err,   1'b1);
    tick();
    do_reset();
    #2;
    chk1("mis_err_clear", align_err,   1'b0);
    chk1("mis_req_again", mem_req,     1'b1);
`else
    #2;
    chk1 ("mis_align_err", align_err, 1'b0);
    chk1 ("mis_req",       mem_req,   1'b1);
    chk32("mis_addr",      mem_addr,  32'h40);
    tick();
    #2;
    tick();
    #2;
    chk1 ("mis_valid", instr_valid, 1'b1);
    chk32("mis_pc",    instr_pc,    32'h40);
    chk32("mis_instr", instr,       32'h1040);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Fetch stage sitting directly upstream of the single-cycle CPU's decode and control logic. Owns the fetch PC and issues word reads to instruction memory. Buffers returned instructions with their PCs in a small in-order queue and hands them to decode over a valid/ready handshake. Branch and jump redirects flush the queue and restart fetch at the target.

## Interface
Parameters:
- DEPTH, 4, number of queue entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all state while 0
- mem_req  out  1  read request to instruction memory
- mem_addr  out  32  word address of the request (byte address, bits [1:0]=00)
- mem_rdata  in  32  instruction word returned by memory
- mem_rvalid  in  1  mem_rdata valid; exactly one response per accepted request, ≥1 cycle after mem_req
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  32  target PC
- instr_valid  out  1  queue head valid
- instr  out  32  head instruction
- instr_pc  out  32  PC of head instruction
- instr_ready  in  1  decode consumes head when instr_valid & instr_ready
- align_err  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- State: fetch PC fpc, outstanding flag osd, drop flag drp, queue (DEPTH entries of {pc, instr}), count.
- Issue: mem_req = !redirect_valid & !halted & (!osd | mem_rvalid) & (count + osd < DEPTH). mem_addr = fpc. On issue: osd←1, fpc←fpc+4 (mod 2^32, wraps FFFF_FFFC→0000_0000), issuing PC recorded for the response.
- Response: mem_rvalid with drp=0 pushes {issued PC, mem_rdata}. With drp=1, the response is discarded and drp←0. osd clears unless a new issue occurs in the same cycle.
- Pop: instr_valid & instr_ready removes the head. Push and pop in the same cycle leave count unchanged.
- Redirect: queue cleared (count←0), fpc←redirect_pc, drp←osd & !mem_rvalid, no issue that cycle. A response arriving in the redirect cycle is discarded. A pop in the redirect cycle completes (decode keeps the instruction), then the flush applies.
- Overflow never occurs; the issue condition reserves a slot for every outstanding request.

## Timing
- Reset values: mem_req 0 while reset=0, mem_addr=RESET_PC, instr_valid 0, instr 0, instr_pc 0, align_err 0, count 0, osd 0, drp 0.
- First mem_req asserts in the first cycle after reset deasserts.
- Latency: with 1-cycle memory, req at cycle N → rvalid at N+1 → instr_valid at N+2. Sustained throughput is 1 instruction/cycle while instr_ready=1.
- Redirect at cycle R: new-target mem_req at R+1; first target instruction valid at R+3 (1-cycle memory).
- Reset asserted mid-operation: immediate flush, any in-flight response ignored; memory must also be reset.

## Configuration
- IFQ_ALIGN_CHECK_EN defined: redirect_pc[1:0]≠00 sets align_err (sticky until reset). The redirect flush still happens, fpc is not loaded, and fetch halts (mem_req held 0) until reset.
- Undefined: redirect_pc[1:0] forced to 00 on load, align_err tied 0, halted always 0.

## Structure
- Shared package cpu_pkg: WORD_W=32, PC_STEP=4, fetch-entry type {pc[31:0], instr[31:0]}.
- Sub-module ifq_fifo: entry storage, read/write pointers, count, flush input. The top level holds fpc, osd/drp, issue logic and the redirect and alignment logic.

## Test plan
- Reset release, RESET_PC=0, 1-cycle memory returning addr+32'h1000, instr_ready=1 → instr_pc 0,4,8,… with instr 1000,1004,…, one per cycle from cycle 2.
- instr_ready=0 for 10 cycles → exactly DEPTH=4 entries held, mem_req 0 once full; release → the 4 entries drain in order, then fetch resumes with no gap beyond 2 cycles.
- redirect_valid with redirect_pc=0x40 while one request is outstanding and the queue holds 3 entries → queue empty next cycle, stale response dropped, first instr_pc=0x40.
- Redirect in the same cycle as mem_rvalid and a pop → popped instruction delivered, response discarded, next instr_pc=target.
- redirect_pc=0xFFFF_FFF8 → instr_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
- With IFQ_ALIGN_CHECK_EN, redirect_pc=0x42 → align_err=1 next cycle, mem_req stays 0; reset clears it. Without the macro → instr_pc=0x40.
